// File: rtl/i2s_pkg.sv
// Shared constants and types for the four-line I2S microphone capture block.
package i2s_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned LINES    = 4;
    localparam int unsigned CHAN_W   = 3;
    localparam int unsigned ENTRY_W  = CHAN_W + SAMPLE_W;
    localparam int unsigned BITCNT_W = 5;
    localparam int unsigned STAT_CNT_W = 5;

    // Bit counter: last data bit of a word, and the saturated "not capturing" value.
    localparam logic [BITCNT_W-1:0] BITCNT_LAST = 5'd16;
    localparam logic [BITCNT_W-1:0] BITCNT_IDLE = 5'd17;

    // Register offsets within the peripheral window.
    localparam logic [15:0] OFF_DATA   = 16'h0000;
    localparam logic [15:0] OFF_STATUS = 16'h0004;
    localparam logic [15:0] OFF_CTRL   = 16'h0008;

    // Register field positions.
    localparam int unsigned DATA_VALID_BIT = 31;
    localparam int unsigned DATA_CHAN_LSB  = 16;
    localparam int unsigned STAT_COUNT_LSB = 0;
    localparam int unsigned STAT_EMPTY_BIT = 8;
    localparam int unsigned STAT_FULL_BIT  = 9;
    localparam int unsigned STAT_OVF_BIT   = 10;
    localparam int unsigned STAT_FLUSH_BIT = 0;
    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_MASK_LSB  = 8;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_PUSH = 1'b1
    } seq_state_e;

    typedef struct packed {
        logic [CHAN_W-1:0]   chan;
        logic [SAMPLE_W-1:0] sample;
    } fifo_entry_t;

    // Channel number of a word: data line pair index times two plus left/right.
    function automatic logic [CHAN_W-1:0] chan_index(input logic [1:0] line, input logic lr);
        return {line, lr};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy flags and a synchronous flush.
module sync_fifo #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata_c,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_nx;

    // A pop frees the slot a same-cycle push needs, so push is allowed when full and popping.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign count_nx = count + CW'(do_push) - CW'(do_pop);
    assign rdata_c  = mem[rptr];

    // Pointers and occupancy; flush wins over any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count_nx;
            full  <= (count_nx == CW'(DEPTH));
            empty <= (count_nx == '0);
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/i2s_capture.sv
// Four-line Philips I2S capture with a word FIFO behind a simple valid/ready bus.
module i2s_capture
    import i2s_pkg::*;
#(
    parameter logic [15:0]  ADDR  = 16'h7000,
    parameter int unsigned  DEPTH = 16
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    input  logic        sck,
    input  logic        ws,
    input  logic [3:0]  sd
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Synchronisers and edge detect
    logic                sck_meta, sck_sync, sck_prev;
    logic                ws_meta, ws_sync;
    logic [LINES-1:0]    sd_meta, sd_sync;
    logic                sck_rise_c;
    logic                ws_change_c;

    // Serial capture
    logic                last_ws;
    logic                chan_lr;
    logic [BITCNT_W-1:0] bitcnt;
    logic [BITCNT_W-1:0] bitcnt_nx;
    logic [SAMPLE_W-1:0] shreg [LINES];
    logic [SAMPLE_W-1:0] hold  [LINES];
    logic                hold_lr;
    logic                commit_c;

    // Push sequencer
    seq_state_e          state, state_nx;
    logic [1:0]          line, line_nx;
    logic [CHAN_W-1:0]   cur_chan;
    logic                push_c;
    fifo_entry_t         push_entry;

    // Register file and bus
    logic                ctrl_en;
    logic [7:0]          ctrl_mask;
    logic                overflow;
    logic                acked;
    logic                acc_c;
    logic                is_wr;
    logic [15:0]         off;
    logic                pop_c;
    logic                flush_c;
    logic [31:0]         rd_word;
    logic [31:0]         status_word;

    // FIFO side
    fifo_entry_t         head;
    logic [CW-1:0]       fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    logic                unused_bits;
    assign unused_bits = ^{iomem_wdata[31:16], iomem_wdata[7:1], iomem_wstrb[3:2]};

    // Two-flop synchronisers on every serial input, plus the previous sck for edge detect.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            sck_meta <= 1'b0;
            sck_sync <= 1'b0;
            sck_prev <= 1'b0;
            ws_meta  <= 1'b0;
            ws_sync  <= 1'b0;
            sd_meta  <= '0;
            sd_sync  <= '0;
        end else begin
            sck_meta <= sck;
            sck_sync <= sck_meta;
            sck_prev <= sck_sync;
            ws_meta  <= ws;
            ws_sync  <= ws_meta;
            sd_meta  <= sd;
            sd_sync  <= sd_meta;
        end
    end

    assign sck_rise_c  = sck_sync && !sck_prev;
    assign ws_change_c = (ws_sync != last_ws);
    assign bitcnt_nx   = bitcnt + BITCNT_W'(1);
    assign commit_c    = ctrl_en && sck_rise_c && !ws_change_c && (bitcnt_nx == BITCNT_LAST);

    // Bit counter, shift registers and word hand-off to the sequencer.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            last_ws <= 1'b0;
            chan_lr <= 1'b0;
            hold_lr <= 1'b0;
            bitcnt  <= BITCNT_IDLE;
            for (int n = 0; n < LINES; n++) begin
                shreg[n] <= '0;
                hold[n]  <= '0;
            end
        end else begin
            if (sck_rise_c) last_ws <= ws_sync;
            if (!ctrl_en) begin
                bitcnt <= BITCNT_IDLE;
            end else if (sck_rise_c) begin
                if (ws_change_c) begin
                    bitcnt  <= '0;
                    chan_lr <= ws_sync;
                end else if (bitcnt != BITCNT_IDLE) begin
                    bitcnt <= bitcnt_nx;
                    if (bitcnt_nx <= BITCNT_LAST) begin
                        for (int n = 0; n < LINES; n++) begin
                            shreg[n] <= {shreg[n][SAMPLE_W-2:0], sd_sync[n]};
                        end
                    end
                    if (commit_c) begin
                        hold_lr <= chan_lr;
                        for (int n = 0; n < LINES; n++) begin
                            hold[n] <= {shreg[n][SAMPLE_W-2:0], sd_sync[n]};
                        end
                    end
                end
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state <= SEQ_IDLE;
            line  <= '0;
        end else begin
            state <= state_nx;
            line  <= line_nx;
        end
    end

    assign cur_chan          = chan_index(line, hold_lr);
    assign push_entry.chan   = cur_chan;
    assign push_entry.sample = hold[line];

    // Sequencer next state: one line per cycle, masked channels still take their cycle.
    always_comb begin
        state_nx = state;
        line_nx  = line;
        push_c   = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (commit_c) begin
                    state_nx = SEQ_PUSH;
                    line_nx  = '0;
                end
            end
            SEQ_PUSH: begin
                push_c  = ctrl_en && ctrl_mask[cur_chan];
                line_nx = line + 2'd1;
                if (line == 2'(LINES - 1)) state_nx = SEQ_IDLE;
            end
        endcase
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (ck),
        .rst_n   (rst),
        .push    (push_c),
        .pop     (pop_c),
        .flush   (flush_c),
        .wdata   (push_entry),
        .rdata_c (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // One access per valid assertion; the access executes on the edge that raises ready.
    assign acc_c   = iomem_valid && (iomem_addr[31:16] == ADDR) && !acked;
    assign is_wr   = |iomem_wstrb;
    assign off     = iomem_addr[15:0];
    assign pop_c   = acc_c && !is_wr && (off == OFF_DATA) && !fifo_empty;
    assign flush_c = acc_c && is_wr && (off == OFF_STATUS) && iomem_wdata[STAT_FLUSH_BIT];

    // Read data mux for the addressed register.
    always_comb begin
        rd_word     = '0;
        status_word = '0;
        status_word[STAT_COUNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
        status_word[STAT_EMPTY_BIT] = fifo_empty;
        status_word[STAT_FULL_BIT]  = fifo_full;
        status_word[STAT_OVF_BIT]   = overflow;
        if (!is_wr) begin
            case (off)
                OFF_DATA: begin
                    if (!fifo_empty) begin
                        rd_word[DATA_VALID_BIT]              = 1'b1;
                        rd_word[DATA_CHAN_LSB +: CHAN_W]     = head.chan;
                        rd_word[SAMPLE_W-1:0]                = head.sample;
                    end
                end
                OFF_STATUS: rd_word = status_word;
                OFF_CTRL: begin
                    rd_word[CTRL_EN_BIT]        = ctrl_en;
                    rd_word[CTRL_MASK_LSB +: 8] = ctrl_mask;
                end
                default: rd_word = '0;
            endcase
        end
    end

    // Bus handshake, read data (zero outside the ack cycle), CTRL and overflow registers.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            acked       <= 1'b0;
            ctrl_en     <= 1'b0;
            ctrl_mask   <= '0;
            overflow    <= 1'b0;
        end else begin
            iomem_ready <= acc_c;
            iomem_rdata <= acc_c ? rd_word : 32'h0;
            acked       <= iomem_valid && (acked || acc_c);
            if (acc_c && is_wr && (off == OFF_CTRL)) begin
                if (iomem_wstrb[0]) ctrl_en   <= iomem_wdata[CTRL_EN_BIT];
                if (iomem_wstrb[1]) ctrl_mask <= iomem_wdata[CTRL_MASK_LSB +: 8];
            end
            if (flush_c) begin
                overflow <= 1'b0;
            end else if (push_c && fifo_full && !pop_c) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/i2s_capture.md
I2S_CAPTURE -- requirements
Module: i2s_capture

Interface
REQ-001 SHALL have parameter ADDR, default 16'h7000, meaning the peripheral matches when iomem_addr[31:16]==ADDR.
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO entries; it SHALL be a power of two.
REQ-003 SHALL have port ck, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port iomem_valid, input, 1, meaning a bus request is present.
REQ-006 SHALL have port iomem_ready, output, 1, meaning the request is acknowledged.
REQ-007 SHALL have port iomem_wstrb, input, 4, byte write strobes; all zero means read.
REQ-008 SHALL have port iomem_addr, input, 32, request address.
REQ-009 SHALL have port iomem_wdata, input, 32, write data.
REQ-010 SHALL have port iomem_rdata, output, 32, read data.
REQ-011 SHALL have port sck, input, 1, I2S bit clock, generated in the ck domain.
REQ-012 SHALL have port ws, input, 1, I2S word select; low means left.
REQ-013 SHALL have port sd, input, 4, serial data from four microphone pairs.

Function
REQ-014 SHALL pass sck, ws and sd[3:0] through identical 2-flop synchronisers, then detect an sck rising edge as synced sck high with the previous value low.
REQ-015 SHALL operate only on detected sck rising edges; at each one it samples ws and sd[3:0].
REQ-016 SHALL treat the edge where sampled ws differs from the last sampled ws as the delay bit (Philips I2S), set bitcnt=0 and latch chan_lr=new ws.
REQ-017 SHALL shift sd[n] MSB-first into per-line 16-bit registers on edges with bitcnt 1..16, then hold bitcnt saturated at 17 until the next ws change.
REQ-018 SHALL, on the edge where bitcnt==16, copy all four shift registers into hold registers and start the push sequencer.
REQ-019 SHALL implement push sequencer states IDLE and PUSH: PUSH walks line 0..3 in four consecutive ck cycles, then returns to IDLE.
REQ-020 SHALL give each word channel index chan = line*2 + chan_lr (0..7).
REQ-021 SHALL skip the push for a channel whose CTRL mask bit is 0; that cycle is still spent.
REQ-022 SHALL make each FIFO entry {chan[2:0], sample[15:0]}, with the sample two's complement as received.
REQ-023 SHALL, on a push while the FIFO is full and no pop occurs in the same cycle, drop the word and set the sticky overflow flag.
REQ-024 SHALL complete both a push and a pop that fall in the same cycle while full.
REQ-025 SHALL, while CTRL.enable=0, perform no shifting or pushing and force bitcnt=17, so capture resumes only after the next ws change.
REQ-026 SHALL, on a matching request, assert iomem_ready exactly one cycle after iomem_valid is first seen, hold it high for one cycle, and not re-acknowledge until iomem_valid drops.
REQ-027 SHALL drive iomem_rdata to zero whenever iomem_ready is low, so the bus can OR it with other peripherals.
REQ-028 SHALL implement offset 0x0 DATA as read-only: bit31=valid, bits18:16=chan, bits15:0=sample; reading it pops one entry.
REQ-029 SHALL return 0 and not pop when DATA is read while the FIFO is empty.
REQ-030 SHALL implement offset 0x4 STATUS read: bits4:0=count, bit8=empty, bit9=full, bit10=overflow.
REQ-031 SHALL, on a STATUS write with wdata bit0=1, flush the FIFO and clear overflow.
REQ-032 SHALL give a flush priority over a push in the same cycle.
REQ-033 SHALL implement offset 0x8 CTRL read/write: bit0=enable, bits15:8=channel mask.
REQ-034 SHALL ignore writes to other offsets and return 0 when they are read.
REQ-035 SHALL require sck period >=4 ck; the sequencer then always finishes before the next commit.

Reset
REQ-036 SHALL, on rst low, asynchronously clear: iomem_ready=0, iomem_rdata=0, FIFO pointers, overflow flag, CTRL (enable=0, mask=0), bitcnt=17, sequencer IDLE and all synchroniser flops.
REQ-037 SHALL, after a reset that lands mid-word or mid-push, discard that partial word and deliver nothing until a fresh ws edge.

Structure
REQ-038 SHALL place register offsets, STATUS/CTRL bit positions and the bitcnt constants 16 and 17 in a shared package i2s_pkg.
REQ-039 SHALL implement the FIFO as one sub-module, sync_fifo: 19 bits wide, DEPTH deep, with push, pop, flush, count, full and empty.

Verification
REQ-040 SHALL cover: enable=1, mask=8'hFF, one frame with sd0 left word 0x8001 and right word 0x7FFE -> DATA reads 0x80008001 then 0x80017FFE.
REQ-041 SHALL cover: mask=8'h04 with line1 left word 0x1234 -> only 0x80021234 is queued and count=1.
REQ-042 SHALL cover: 3 frames at mask 8'hFF without reads -> count=16, full=1, overflow=1; a write of 1 to STATUS -> count=0 and overflow=0.
REQ-043 SHALL cover: a DATA read with the FIFO empty -> rdata 0x00000000 and count stays 0.
REQ-044 SHALL cover: enable rising mid-word -> the partial word is not queued and the first entry is the next complete word.
REQ-045 SHALL cover: rst asserted during PUSH -> all outputs 0 immediately, count=0 after release, and iomem_rdata stays 0 for non-matching ADDR.
